// File: rtl/multicycle_cpu.sv
// multicycle_cpu
// Multi-cycle 16-bit-instruction CPU with an 8-entry register file, ALU,
// program counter and separate instruction/data memory ports.
// Every instruction is fetched in FETCH and decoded in EXEC. ALU ops, LDI
// and ADI write back in EXEC. Branches and JMP redirect the PC in EXEC.
// LD/ST perform a single data access in MEM. An unknown opcode parks the
// core in HALT until reset.
//
// Handshake (both memory ports): req is a Moore output of the state
// register. It stays high until the cycle in which ready=1, and that cycle
// completes the transfer. Address, write data and we are held stable while
// req is high. ready is ignored while req is low. While reset is high all
// requests are forced low.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   imem_req/addr     fetch request, fetch address (= PC)
//   imem_ready/data   fetch completes this cycle, instruction word
//   dmem_req/we       data request, 1 = store / 0 = load
//   dmem_addr/wdata   R[SA] resized to ADDR_W, R[SB]
//   dmem_ready/rdata  access completes this cycle, load data
//   flags             {V,C,N,Z} of the last ALU-class instruction
//   halted            core stopped on an illegal opcode
module multicycle_cpu #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [15:0]       imem_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [3:0]        flags,
   output logic              halted
);
   localparam int MSB = DATA_W - 1;

   localparam logic [6:0] OP_MOVA = 7'b0000000;
   localparam logic [6:0] OP_INC  = 7'b0000001;
   localparam logic [6:0] OP_ADD  = 7'b0000010;
   localparam logic [6:0] OP_SUB  = 7'b0000101;
   localparam logic [6:0] OP_DEC  = 7'b0000110;
   localparam logic [6:0] OP_AND  = 7'b0001000;
   localparam logic [6:0] OP_OR   = 7'b0001001;
   localparam logic [6:0] OP_XOR  = 7'b0001010;
   localparam logic [6:0] OP_NOT  = 7'b0001011;
   localparam logic [6:0] OP_MOVB = 7'b0001100;
   localparam logic [6:0] OP_SHR  = 7'b0001101;
   localparam logic [6:0] OP_SHL  = 7'b0001110;
   localparam logic [6:0] OP_LDI  = 7'b1001100;
   localparam logic [6:0] OP_ADI  = 7'b1000010;
   localparam logic [6:0] OP_LD   = 7'b0010000;
   localparam logic [6:0] OP_ST   = 7'b0100000;
   localparam logic [6:0] OP_BRZ  = 7'b1100000;
   localparam logic [6:0] OP_BRN  = 7'b1100001;
   localparam logic [6:0] OP_JMP  = 7'b1110000;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
   state_t state, state_n;

   logic [ADDR_W-1:0] pc, pc_n, pc_inc;
   logic [15:0]       ir;
   logic [DATA_W-1:0] rf [0:7];
   logic [3:0]        flags_q;

   logic              ir_load, rf_we, flags_we;
   logic [DATA_W-1:0] rf_wdata;

   // Instruction fields
   logic [6:0]        opcode;
   logic [2:0]        dr, sa, sb;
   logic [DATA_W-1:0] a, b, op_ext;
   logic signed [5:0] ad6;
   logic [ADDR_W-1:0] ad_ext;

   assign opcode = ir[15:9];
   assign dr     = ir[8:6];
   assign sa     = ir[5:3];
   assign sb     = ir[2:0];
   assign a      = rf[sa];
   assign b      = rf[sb];
   assign op_ext = DATA_W'(sb);
   assign ad6    = {dr, sb};
   // Signed source, so the resize sign-extends the branch displacement.
   assign ad_ext = ADDR_W'(ad6);
   assign pc_inc = pc + ADDR_W'(1);

   // Shared adder for the add/sub class. Subtraction is a + ~b + 1, so the
   // carry out is directly the NOT-borrow flag; DEC adds all-ones.
   logic [DATA_W-1:0] add_x, add_y;
   logic              add_cin, add_v;
   logic [DATA_W:0]   sum;

   always_comb begin
      add_x   = a;
      add_y   = '0;
      add_cin = 1'b0;
      case (opcode)
         OP_INC: add_cin = 1'b1;
         OP_ADD: add_y = b;
         OP_SUB: begin
            add_y   = ~b;
            add_cin = 1'b1;
         end
         OP_DEC: add_y = '1;
         OP_ADI: add_y = op_ext;
         default: ;
      endcase
   end

   assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
   assign add_v = (add_x[MSB] == add_y[MSB]) && (sum[MSB] != add_x[MSB]);

   // ALU result and carry/overflow; is_alu marks instructions that write
   // R[DR] and the flags in EXEC.
   logic [DATA_W-1:0] alu_res;
   logic              alu_c, alu_v, is_alu;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      is_alu  = 1'b1;
      case (opcode)
         OP_MOVA: alu_res = a;
         OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_ADI: begin
            alu_res = sum[MSB:0];
            alu_c   = sum[DATA_W];
            alu_v   = add_v;
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOT:  alu_res = ~a;
         OP_MOVB: alu_res = b;
         OP_SHR: begin
            alu_res = {1'b0, b[MSB:1]};
            alu_c   = b[0];
         end
         OP_SHL: begin
            alu_res = {b[MSB-1:0], 1'b0};
            alu_c   = b[MSB];
         end
         OP_LDI:  alu_res = op_ext;
         default: is_alu = 1'b0;
      endcase
   end

   // Next-state, PC update and memory-port outputs
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      ir_load  = 1'b0;
      rf_we    = 1'b0;
      rf_wdata = alu_res;
      flags_we = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_load = 1'b1;
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            state_n = S_FETCH;
            if (is_alu) begin
               rf_we    = 1'b1;
               flags_we = 1'b1;
               pc_n     = pc_inc;
            end else begin
               case (opcode)
                  OP_BRZ:       pc_n = (a == '0) ? pc + ad_ext : pc_inc;
                  OP_BRN:       pc_n = a[MSB] ? pc + ad_ext : pc_inc;
                  OP_JMP:       pc_n = ADDR_W'(a);
                  OP_LD, OP_ST: state_n = S_MEM;
                  default:      state_n = S_HALT;
               endcase
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode == OP_ST);
            if (dmem_ready) begin
               rf_we    = (opcode == OP_LD);
               rf_wdata = dmem_rdata;
               pc_n     = pc_inc;
               state_n  = S_FETCH;
            end
         end
         S_HALT: ;
         default: state_n = S_FETCH;
      endcase
      // An access in flight when reset rises is abandoned immediately.
      if (reset) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         pc      <= '0;
         ir      <= '0;
         flags_q <= '0;
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         if (ir_load) ir <= imem_data;
         if (rf_we) rf[dr] <= rf_wdata;
         if (flags_we) flags_q <= {alu_v, alu_c, alu_res[MSB], alu_res == '0};
      end
   end

   assign imem_addr  = pc;
   assign dmem_addr  = ADDR_W'(a);
   assign dmem_wdata = b;
   assign flags      = flags_q;
   assign halted     = (state == S_HALT);

endmodule
